sample_stream_tx: RTL and testbench

- Transmit side of the packed sample interface consumed by the moving-average filter.
- Accepts 2-bit x/y/t samples over a valid/ready handshake and buffers them in a small FIFO.
- Emits one packed word {p[1:0], t[1:0], y[1:0], x[1:0]} every PERIOD clocks. Valid words carry p=2'b11; idle cycles drive 8'h00.
- Sits upstream of the filter; out_word connects directly to the filter's 8-bit sample input.

---
 rtl/sample_stream_tx.sv | 117 +++++++++++
 tb/tb_sample_stream_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sample_stream_tx.sv
// sample_stream_tx: buffers 2-bit x/y/t samples in a small FIFO and emits one
// packed word {p,t,y,x} per PERIOD-clock slot while enabled.
// Optional feature macro: SAMPLE_TX_HOLD_EN (an underrun slot re-emits the last word).
module sample_stream_tx #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PERIOD = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_x,
  input  logic [1:0]               in_y,
  input  logic [1:0]               in_t,
  output logic [7:0]               out_word,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [0:0]    state;
  logic          slot;
  logic          push;
  logic          pop;
  logic          empty;
  logic [5:0]    head;

  assign empty     = (level == '0);
  assign in_ready  = (level != LW'(DEPTH));
  // The first enabled cycle always carries a slot; the counter sits at 0 in IDLE.
  assign slot      = en && ((state == ST_IDLE) || (cnt == '0));
  assign push      = in_valid && in_ready && !clr;
  assign pop       = slot && !empty && !clr;
  assign head      = mem[rd_ptr];
  assign out_valid = (out_word[7:6] == 2'b11);

  // Run/idle state follows en; clr does not disturb it.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= en ? ST_RUN : ST_IDLE;
  end

  // Slot counter: free-runs 0..PERIOD-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n)                        cnt <= '0;
    else if (clr || !en)               cnt <= '0;
    else if (cnt == CW'(PERIOD - 1))   cnt <= '0;
    else                               cnt <= cnt + CW'(1);
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= {in_t, in_y, in_x};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky underrun flag, cleared only by reset or flush.
  always_ff @(posedge clk) begin
    if (!rst_n || clr)       underrun <= 1'b0;
    else if (slot && empty)  underrun <= 1'b1;
  end

`ifdef SAMPLE_TX_HOLD_EN
  logic [7:0] last_word;

  // Last emitted word, replayed when a slot finds the FIFO empty.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) last_word <= 8'h00;
    else if (pop)      last_word <= {2'b11, head};
  end

  // Output word: one-cycle pulse per slot, idle zeros otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n || clr)      out_word <= 8'h00;
    else if (pop)           out_word <= {2'b11, head};
    else if (slot && empty) out_word <= {2'b11, last_word[5:0]};
    else                    out_word <= 8'h00;
  end
`else
  // Output word: one-cycle pulse per slot, idle zeros otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) out_word <= 8'h00;
    else if (pop)      out_word <= {2'b11, head};
    else               out_word <= 8'h00;
  end
`endif

endmodule

// File: tb/tb_sample_stream_tx.sv
// Scoreboard bench for sample_stream_tx: two instances (PERIOD=4 and PERIOD=1)
// share one stimulus stream; a queue-based reference model predicts each word.
module tb_sample_stream_tx;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n, en, clr, in_valid;
  logic [1:0] in_x, in_y, in_t;

  logic [7:0] ow0, ow1;
  logic       ov0, ov1, rdy0, rdy1, ur0, ur1;
  logic [2:0] lv0, lv1;

  always #5 clk = ~clk;

  sample_stream_tx #(.DEPTH(DEPTH), .PERIOD(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid),
    .in_ready(rdy0), .in_x(in_x), .in_y(in_y), .in_t(in_t),
    .out_word(ow0), .out_valid(ov0), .level(lv0), .underrun(ur0)
  );

  sample_stream_tx #(.DEPTH(DEPTH), .PERIOD(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid),
    .in_ready(rdy1), .in_x(in_x), .in_y(in_y), .in_t(in_t),
    .out_word(ow1), .out_valid(ov1), .level(lv1), .underrun(ur1)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Reference model: per-instance sample queue, cycles-since-enable, flags.
  int          per [2] = '{4, 1};
  logic [5:0]  mq0 [$];
  logic [5:0]  mq1 [$];
  int          m_age [2];
  logic        m_under [2];
  logic [7:0]  m_last [2];
  logic [7:0]  exp0 [$];
  logic [7:0]  exp1 [$];

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[inst%0d] t=%0t got=%0h exp=%0h", nm, i, $time, got, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic model_step(input int i);
    logic [5:0] s;
    bit         slot;
    bit         ready;
    if (!rst_n) begin
      if (i == 0) mq0.delete(); else mq1.delete();
      m_age[i] = 0; m_under[i] = 1'b0; m_last[i] = 8'h00;
      return;
    end
    if (clr) begin
      if (i == 0) mq0.delete(); else mq1.delete();
      m_age[i] = 0; m_under[i] = 1'b0; m_last[i] = 8'h00;
      return;
    end
    ready = (qsize(i) < DEPTH);
    slot  = en && ((m_age[i] % per[i]) == 0);
    m_age[i] = en ? m_age[i] + 1 : 0;
    if (slot) begin
      if (qsize(i) > 0) begin
        s = (i == 0) ? mq0.pop_front() : mq1.pop_front();
        m_last[i] = {2'b11, s};
        if (i == 0) exp0.push_back({2'b11, s}); else exp1.push_back({2'b11, s});
      end else begin
        m_under[i] = 1'b1;
`ifdef SAMPLE_TX_HOLD_EN
        if (i == 0) exp0.push_back({2'b11, m_last[i][5:0]});
        else        exp1.push_back({2'b11, m_last[i][5:0]});
`endif
      end
    end
    if (in_valid && ready) begin
      if (i == 0) mq0.push_back({in_t, in_y, in_x});
      else        mq1.push_back({in_t, in_y, in_x});
    end
  endtask

  task automatic mon(input int i, input logic [7:0] w, input logic v,
                     input logic [2:0] lv, input logic rdy, input logic ur);
    logic [7:0] e;
    bit         expv;
    chk("level", i, 32'(lv), 32'(qsize(i)));
    chk("in_ready", i, 32'(rdy), 32'(qsize(i) < DEPTH));
    chk("underrun", i, 32'(ur), 32'(m_under[i]));
    expv = (i == 0) ? (exp0.size() > 0) : (exp1.size() > 0);
    chk("out_valid", i, 32'(v), 32'(expv));
    if (expv) begin
      if (i == 0) e = exp0.pop_front(); else e = exp1.pop_front();
    end else begin
      e = 8'h00;
    end
    chk("out_word", i, 32'(w), 32'(e));
  endtask

  // Monitor: compares every output cycle away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        mon(0, ow0, ov0, lv0, rdy0, ur0);
        mon(1, ow1, ov1, lv1, rdy1, ur1);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    if (!rst_n) chk_on = 1'b1;
    #1;
  endtask

  task automatic offer(input logic [1:0] x, input logic [1:0] y, input logic [1:0] t);
    in_valid = 1'b1; in_x = x; in_y = y; in_t = t;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0;
    offer(2'd1, 2'd1, 2'd1);

    // Reset held with a sample offered: nothing may be pushed.
    repeat (3) cyc();
    rst_n = 1'b1; in_valid = 1'b0;
    cyc();

    // Basic emit: expect F9 then D3 one period later.
    offer(2'd1, 2'd2, 2'd3); cyc();
    offer(2'd3, 2'd0, 2'd1); cyc();
    in_valid = 1'b0; en = 1'b1;
    repeat (10) cyc();
    en = 1'b0; cyc();

    // Backpressure: six offers into a four-entry FIFO, then drain in order.
    clr = 1'b1; cyc(); clr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      offer(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      cyc();
    end
    in_valid = 1'b0; en = 1'b1;
    repeat (24) cyc();
    en = 1'b0; cyc();

    // Underrun on an empty FIFO for eight enabled cycles.
    clr = 1'b1; cyc(); clr = 1'b0;
    en = 1'b1;
    repeat (8) cyc();
    en = 1'b0; cyc();

    // Flush coinciding with a push.
    for (int k = 0; k < 3; k++) begin
      offer(2'(k), 2'(k + 1), 2'(k + 2));
      cyc();
    end
    offer(2'd3, 2'd3, 2'd3); clr = 1'b1; cyc();
    clr = 1'b0; in_valid = 1'b0;
    repeat (2) cyc();

    // Continuous stream while enabled.
    clr = 1'b1; cyc(); clr = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      offer(2'(k), 2'(3 - k), 2'(k + 1));
      cyc();
    end
    in_valid = 1'b0;
    repeat (6) cyc();
    en = 1'b0; cyc();

    // Randomized traffic with occasional enable toggles, flushes and resets.
    repeat (800) begin
      rst_n = ($urandom_range(0, 99) != 0);
      clr   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 11) == 0) en = ~en;
      in_valid = 1'($urandom_range(0, 1));
      in_x = 2'($urandom_range(0, 3));
      in_y = 2'($urandom_range(0, 3));
      in_t = 2'($urandom_range(0, 3));
      cyc();
    end

    rst_n = 1'b1; clr = 1'b0; en = 1'b0; in_valid = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
